// File: rtl/line_responder_if.sv
// Cache-side line port plus narrow memory-side beat bus for line_responder.
interface line_responder_if #(
  parameter int LINES_W    = 128,
  parameter int MEM_W      = 32,
  parameter int EXT_ADDR_W = 26
);
  localparam int BEATS      = LINES_W / MEM_W;
  localparam int MEM_ADDR_W = EXT_ADDR_W + $clog2(BEATS);

  logic                  ext_read_rq;
  logic                  ext_write_rq;
  logic [EXT_ADDR_W-1:0] ext_address;
  logic [LINES_W-1:0]    ext_write_data;
  logic [LINES_W-1:0]    ext_read_data;
  logic                  ext_rq_finished;

  logic                  mem_req;
  logic                  mem_we;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]      mem_wdata;
  logic                  mem_ack;
  logic [MEM_W-1:0]      mem_rdata;

  // responder side: serves the cache and drives the memory bus
  modport slave (
    input  ext_read_rq, ext_write_rq, ext_address, ext_write_data, mem_ack, mem_rdata,
    output ext_read_data, ext_rq_finished, mem_req, mem_we, mem_addr, mem_wdata
  );

  // requester/memory-model side
  modport master (
    output ext_read_rq, ext_write_rq, ext_address, ext_write_data, mem_ack, mem_rdata,
    input  ext_read_data, ext_rq_finished, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/line_responder.sv
// Splits one line read/write into BEATS single-outstanding memory beats; finish pulse 1+BEATS+waits after accept.
// Stalls on mem_ack (mem_req held with stable addr/we); cache request is only sampled in IDLE.
module line_responder #(
  parameter int LINES_W    = 128,
  parameter int MEM_W      = 32,
  parameter int EXT_ADDR_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  line_responder_if.slave  bus
);
  localparam int BEATS  = LINES_W / MEM_W;
  localparam int BEAT_W = $clog2(BEATS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [EXT_ADDR_W-1:0] r_addr;
  logic                  r_we;
  logic [BEAT_W-1:0]     r_beat;
  logic [LINES_W-1:0]    r_wline;
  logic [LINES_W-1:0]    r_rline;

  logic                  w_accept;
  logic                  w_ack;
  logic                  w_last;

  assign w_accept = (r_state == S_IDLE) && (bus.ext_read_rq || bus.ext_write_rq);
  assign w_ack    = (r_state == S_XFER) && bus.mem_ack;
  assign w_last   = (r_beat == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_XFER;
      S_XFER:  if (w_ack && w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Write wins when both requests are up; the latched line feeds the write beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_beat  <= '0;
      r_wline <= '0;
      r_rline <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= bus.ext_address;
        r_we    <= bus.ext_write_rq;
        r_wline <= bus.ext_write_data;
        r_beat  <= '0;
      end else if (w_ack && !w_last) begin
        r_beat <= r_beat + 1'b1;
      end
      if (w_ack && !r_we) begin
        r_rline[int'(r_beat)*MEM_W +: MEM_W] <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    bus.mem_req         = (r_state == S_XFER);
    bus.ext_rq_finished = (r_state == S_DONE);
    bus.mem_we          = r_we;
    bus.mem_addr        = {r_addr, r_beat};
    bus.mem_wdata       = r_wline[int'(r_beat)*MEM_W +: MEM_W];
    bus.ext_read_data   = r_rline;
  end
endmodule

// File: tb/tb_line_responder.sv
// Directed bench for line_responder: scoreboard of expected beats, bench-driven memory with wait states.
`timescale 1ns/1ps
module tb_line_responder;
  localparam int LINES_W    = 128;
  localparam int MEM_W      = 32;
  localparam int EXT_ADDR_W = 26;
  localparam int BEATS      = 4;

  typedef struct packed {
    logic        we;
    logic [27:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } beat_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     accept_cyc = 0;
  int     fin_cnt = 0;
  int     beat_cnt = 0;
  logic [127:0] exp_rline = '0;
  beat_t  sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_responder_if #(.LINES_W(LINES_W), .MEM_W(MEM_W), .EXT_ADDR_W(EXT_ADDR_W)) bif ();

  line_responder #(.LINES_W(LINES_W), .MEM_W(MEM_W), .EXT_ADDR_W(EXT_ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic idle_watch(input int n, input string nm);
    int reqs = 0;
    int fins = 0;
    repeat (n) begin
      @(negedge clk);
      if (bif.mem_req) reqs++;
      if (bif.ext_rq_finished) fins++;
    end
    check({nm, "_idle_req"}, reqs, 0);
    check({nm, "_idle_fin"}, fins, 0);
  endtask

  // One line transaction; rst_beat >= 0 asserts reset while that beat is pending.
  task automatic run(input logic wr, input logic rd, input logic [25:0] a,
                     input logic [127:0] wl, input logic [127:0] rl,
                     input int w0, input int w1, input int w2, input int w3,
                     input int rst_beat, input string nm);
    int wt[4];
    int c = 0;
    int k = 0;
    int exp_fin;
    bit done = 0;
    bit aborted = 0;
    wt = '{w0, w1, w2, w3};
    exp_fin = 1 + BEATS + w0 + w1 + w2 + w3;
    sb.delete();
    for (int i = 0; i < BEATS; i++) begin
      beat_t b;
      b.we    = wr;
      b.addr  = {a, 2'(i)};
      b.wdata = wl[i*32 +: 32];
      b.rdata = rl[i*32 +: 32];
      sb.push_back(b);
    end
    @(negedge clk);
    bif.ext_write_rq   = wr;
    bif.ext_read_rq    = rd;
    bif.ext_address    = a;
    bif.ext_write_data = wl;
    @(posedge clk);
    accept_cyc = cyc;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      bif.mem_ack        = 1'b0;
      bif.ext_address    = ~a;
      bif.ext_write_data = ~wl;
      if (bif.ext_rq_finished) begin
        check({nm, "_fin_cycle"}, c, exp_fin);
        fin_cnt++;
        done = 1;
      end else if (bif.mem_req) begin
        if (sb.size() == 0) begin
          check({nm, "_extra_beat"}, bif.mem_req, 1'b0);
        end else begin
          check({nm, "_addr"}, bif.mem_addr, sb[0].addr);
          check({nm, "_we"}, bif.mem_we, sb[0].we);
          if (sb[0].we) check({nm, "_wdata"}, bif.mem_wdata, sb[0].wdata);
          bif.mem_rdata = sb[0].rdata;
          if (k == rst_beat) begin
            rst_n = 1'b0;
            bif.ext_read_rq  = 1'b0;
            bif.ext_write_rq = 1'b0;
            @(negedge clk);
            check({nm, "_rst_req"}, bif.mem_req, 1'b0);
            check({nm, "_rst_rdata"}, bif.ext_read_data, '0);
            check({nm, "_rst_fin"}, bif.ext_rq_finished, 1'b0);
            rst_n = 1'b1;
            exp_rline = '0;
            aborted = 1;
            done = 1;
          end else if (wt[k] > 0) begin
            wt[k]--;
          end else begin
            bif.mem_ack = 1'b1;
            beat_cnt++;
            void'(sb.pop_front());
            k++;
          end
        end
      end
    end
    bif.mem_ack      = 1'b0;
    bif.ext_read_rq  = 1'b0;
    bif.ext_write_rq = 1'b0;
    if (!done) check({nm, "_timeout"}, bif.ext_rq_finished, 1'b1);
    if (aborted) begin
      idle_watch(4, {nm, "_after_rst"});
    end else begin
      check({nm, "_beats_left"}, sb.size(), 0);
      if (rd && !wr) exp_rline = rl;
      check({nm, "_rdata"}, bif.ext_read_data, exp_rline);
    end
  endtask

  initial begin
    int a1;
    int f0;
    int b0;
    bif.ext_read_rq    = 1'b0;
    bif.ext_write_rq   = 1'b0;
    bif.ext_address    = '0;
    bif.ext_write_data = '0;
    bif.mem_ack        = 1'b0;
    bif.mem_rdata      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fin", bif.ext_rq_finished, 1'b0);
    check("rst_req", bif.mem_req, 1'b0);
    check("rst_we", bif.mem_we, 1'b0);
    check("rst_addr", bif.mem_addr, '0);
    check("rst_wdata", bif.mem_wdata, '0);
    check("rst_rdata", bif.ext_read_data, '0);
    rst_n = 1'b1;

    run(1'b0, 1'b1, 26'h0000123, 128'h0,
        128'h44444444_33333333_22222222_11111111, 0, 0, 0, 0, -1, "rd0");

    run(1'b1, 1'b0, 26'h3FFFFFF, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D,
        128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 0, 0, 0, 0, -1, "wr0");

    run(1'b0, 1'b1, 26'h155AA55, 128'h0,
        128'h0BADF00D_76543210_FEDCBA98_13579BDF, 0, 3, 0, 1, -1, "rdwait");

    run(1'b1, 1'b1, 26'h0ABCDEF, 128'h11223344_55667788_99AABBCC_DDEEFF00,
        128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC, 0, 1, 0, 0, -1, "both");
    idle_watch(6, "both");

    run(1'b0, 1'b1, 26'h0000042, 128'h0,
        128'h9999AAAA_7777BBBB_5555CCCC_3333DDDD, 0, 0, 0, 0, 2, "rdrst");
    run(1'b0, 1'b1, 26'h2000001, 128'h0,
        128'h01010101_02020202_03030303_04040404, 1, 0, 2, 0, -1, "rdpost");

    f0 = fin_cnt;
    b0 = beat_cnt;
    run(1'b0, 1'b1, 26'h0001000, 128'h0,
        128'hC0C0C0C0_B0B0B0B0_A0A0A0A0_90909090, 0, 0, 0, 0, -1, "b2b_a");
    a1 = accept_cyc;
    run(1'b0, 1'b1, 26'h0001001, 128'h0,
        128'h1F1F1F1F_2E2E2E2E_3D3D3D3D_4C4C4C4C, 0, 0, 0, 0, -1, "b2b_b");
    check("b2b_gap", accept_cyc - a1, 6);
    idle_watch(4, "b2b");
    check("b2b_fins", fin_cnt - f0, 2);
    check("b2b_beats", beat_cnt - b0, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/line_responder.md
# line_responder

Memory-side responder for the cache's external line port: accepts one full-line read or write request from the write-through cache and splits it into `LINES_W/MEM_W` sequential beats on a narrow, single-outstanding memory bus toward the DDR3 controller. Reads are reassembled into one line and returned with a single `ext_rq_finished` pulse. Writes are sliced into beats and acknowledged the same way. The block sits directly between the cache's `ext_*` port and the memory controller front end.

## Interface
- `LINES_W`, 128, line width in bits; must be a multiple of `MEM_W`.
- `MEM_W`, 32, memory bus data width; `BEATS = LINES_W/MEM_W` must be a power of two, ≥2.
- `EXT_ADDR_W`, 26, line address width.
- derived `MEM_ADDR_W = EXT_ADDR_W + log2(BEATS)`; not overridable.

Ports (the clock is `clk`; `rst_n` is a synchronous, active-low reset):
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `ext_read_rq`  in  1  line read request; level, held until finished.
- `ext_write_rq`  in  1  line write request; level, held until finished.
- `ext_address`  in  EXT_ADDR_W  line address.
- `ext_write_data`  in  LINES_W  line to write.
- `ext_read_data`  out  LINES_W  assembled read line.
- `ext_rq_finished`  out  1  one-cycle completion pulse.
- `mem_req`  out  1  beat request; held until `mem_ack`.
- `mem_we`  out  1  1 = write beat, 0 = read beat.
- `mem_addr`  out  MEM_ADDR_W  `{latched ext_address, beat index}`.
- `mem_wdata`  out  MEM_W  write beat data.
- `mem_ack`  in  1  beat complete; for reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  MEM_W  read beat data.

## Operation
- FSM states:
  - IDLE: when `ext_write_rq` or `ext_read_rq` is sampled high, latch address, direction and `ext_write_data`; clear the beat counter; go to XFER.
  - XFER: drive `mem_req=1` with `mem_addr={addr, beat}`.
    - On `mem_ack`, if beat = `BEATS-1`, go to DONE.
    - Otherwise increment beat and stay in XFER. `mem_req` stays high and the address advances the next cycle.
  - DONE: `ext_rq_finished=1` for exactly one cycle, then return to IDLE.
- Beat ordering: beat k carries line bits `[k*MEM_W +: MEM_W]`. Beat 0 is the least significant.
  - Write: `mem_wdata` is slice k of the latched line.
  - Read: `mem_rdata` on ack is stored into slice k of `ext_read_data`.
- `ext_read_data` changes only on read-beat acks. Write requests never modify it. It holds its value indefinitely after DONE.
- Both requests high in IDLE: the write wins; the read is ignored for this transaction.
- Request inputs and `ext_*` data are ignored outside IDLE. Changes to them mid-transaction have no effect.
- `mem_ack` while `mem_req=0` is ignored.
- Requester rule: the request must be low in the cycle after `ext_rq_finished`. IDLE samples it again in that cycle, so a request still high there is treated as a new request.
- The beat counter is log2(BEATS) bits and is cleared on accept. It never wraps within a transaction.

## Timing
- Reset (`rst_n=0` at a rising edge) gives state IDLE and clears all outputs: `ext_rq_finished`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `ext_read_data` all 0.
- Reset mid-transaction abandons the transfer immediately:
  - `mem_req` drops the cycle after the reset edge.
  - No finished pulse is issued.
- Latency from the accept edge to the finished pulse is `1 + BEATS + total wait cycles`.
  - With zero-wait acks, `BEATS=4`: request sampled at edge 0; `mem_req` high in cycles 1–4; `ext_rq_finished` high in cycle 5.
- Back-to-back throughput: one line per `BEATS+2` cycles minimum (accept, beats, DONE).
- `mem_we` and `mem_addr` are stable while `mem_req=1` and unacked.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Read, zero-wait, `BEATS=4`, address `0x0000123`, memory returns `0x11111111`…`0x44444444`:
  - `mem_addr` = `0x000048C`..`0x000048F`, `mem_we=0`.
  - Finished in cycle 5.
  - `ext_read_data=0x44444444_33333333_22222222_11111111`.
- Write of `0xDEADBEEF_01234567_89ABCDEF_CAFEF00D` to `0x3FFFFFF`:
  - `mem_wdata` beats are `CAFEF00D, 89ABCDEF, 01234567, DEADBEEF`.
  - `mem_addr` = `0xFFFFFFC`..`0xFFFFFFF`.
  - `ext_read_data` is unchanged.
- Read with 3 wait cycles on beat 1 and 1 on beat 3:
  - Address holds during waits.
  - Finished at cycle 9.
  - Data is correct.
- `ext_read_rq` and `ext_write_rq` high together:
  - Only write beats are issued (`mem_we=1`), followed by one finished pulse.
  - After the requests drop, no read is issued.
- Reset asserted during beat 2 of a read:
  - Next cycle `mem_req=0`, `ext_read_data=0`.
  - No finished pulse.
  - A new read issued after reset completes normally.
- Two consecutive reads, each with the request dropped in the cycle after finished:
  - Exactly 2 × 4 beats are issued and 2 finished pulses.
  - The second read's address starts at cycle 6 from the first accept.
